// File: rtl/ika9958_vram_arb.sv
// VRAM access arbiter/sequencer: hands free display slots to the CPU or the
// command engine and runs one RAS/CAS/WE cycle per granted slot.
//
// Request/acknowledge handshake (CPU and command ports behave identically):
// a requester raises REQ with RD/ADDR/WDATA stable and holds them until its
// ACK. ACK is a single i_XTAL1-cycle pulse on the first clock of DONE. The
// grant latches the fields, so dropping REQ after the grant does not cancel
// the access. A REQ still high once the sequencer is back in IDLE counts as
// a new request.
module ika9958_vram_arb #(
  parameter int AW         = 17,
  parameter int STARVE_MAX = 2
) (
  input  logic          i_XTAL1,
  input  logic          i_RST_n,
  input  logic          i_CEN,
  input  logic          i_SLOT_START,
  input  logic          i_SLOT_FREE,
  input  logic          i_DISP_OFF,
  input  logic          i_CPU_REQ,
  input  logic          i_CPU_RD,
  input  logic [AW-1:0] i_CPU_ADDR,
  input  logic [7:0]    i_CPU_WDATA,
  output logic          o_CPU_ACK,
  input  logic          i_CMD_REQ,
  input  logic          i_CMD_RD,
  input  logic [AW-1:0] i_CMD_ADDR,
  input  logic [7:0]    i_CMD_WDATA,
  output logic          o_CMD_ACK,
  output logic [7:0]    o_RDATA,
  output logic [AW-1:0] o_VA,
  output logic [7:0]    o_VDO,
  output logic          o_VDO_OE,
  input  logic [7:0]    i_VDI,
  output logic          o_RAS_n,
  output logic          o_CAS_n,
  output logic          o_WE_n,
  output logic          o_BUSY,
  output logic [1:0]    o_DBG_STATE,
  output logic [1:0]    o_DBG_STARVE
);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, DONE = 2'd3} state_t;

  state_t      state;
  logic [1:0]  starve_cnt;
  logic        rd_q;
  logic [7:0]  wdata_q;
  logic        owner_q;   // 1 = command engine owns the current access

  logic        slot_ok;
  logic        grant;
  logic        cmd_starved;
  logic        cmd_win;

  // A usable slot: CEN-qualified start that display/refresh left free.
  assign slot_ok     = i_CEN & i_SLOT_START & (i_SLOT_FREE | i_DISP_OFF);
  assign grant       = (state == IDLE) & slot_ok & (i_CPU_REQ | i_CMD_REQ);
  assign cmd_starved = ({30'd0, starve_cnt} >= 32'(STARVE_MAX));
  // CPU has priority unless the command engine has waited long enough.
  assign cmd_win     = i_CMD_REQ & (~i_CPU_REQ | cmd_starved);

  assign o_DBG_STATE  = state;
  assign o_DBG_STARVE = starve_cnt;

  // Sequencer FSM with registered DRAM strobes, data bus and acknowledges.
  always_ff @(posedge i_XTAL1 or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state     <= IDLE;
      rd_q      <= 1'b0;
      wdata_q   <= 8'd0;
      owner_q   <= 1'b0;
      o_VA      <= '0;
      o_VDO     <= 8'd0;
      o_VDO_OE  <= 1'b0;
      o_RDATA   <= 8'd0;
      o_RAS_n   <= 1'b1;
      o_CAS_n   <= 1'b1;
      o_WE_n    <= 1'b1;
      o_BUSY    <= 1'b0;
      o_CPU_ACK <= 1'b0;
      o_CMD_ACK <= 1'b0;
    end else begin
      // Acks last one master clock, independent of CEN.
      o_CPU_ACK <= 1'b0;
      o_CMD_ACK <= 1'b0;
      if (i_CEN) begin
        case (state)
          IDLE: begin
            if (grant) begin
              state   <= ADDR;
              owner_q <= cmd_win;
              rd_q    <= cmd_win ? i_CMD_RD    : i_CPU_RD;
              wdata_q <= cmd_win ? i_CMD_WDATA : i_CPU_WDATA;
              o_VA    <= cmd_win ? i_CMD_ADDR  : i_CPU_ADDR;
              o_RAS_n <= 1'b0;
              o_BUSY  <= 1'b1;
            end
          end
          ADDR: begin
            state   <= DATA;
            o_CAS_n <= 1'b0;
            if (!rd_q) begin
              o_WE_n   <= 1'b0;
              o_VDO_OE <= 1'b1;
              o_VDO    <= wdata_q;
            end
          end
          DATA: begin
            state    <= DONE;
            o_RAS_n  <= 1'b1;
            o_CAS_n  <= 1'b1;
            o_WE_n   <= 1'b1;
            o_VDO_OE <= 1'b0;
            if (rd_q) o_RDATA <= i_VDI;
            o_CPU_ACK <= ~owner_q;
            o_CMD_ACK <= owner_q;
          end
          DONE: begin
            state  <= IDLE;
            o_BUSY <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Starvation counter: counts CPU wins over a waiting command engine.
  always_ff @(posedge i_XTAL1 or negedge i_RST_n) begin
    if (!i_RST_n) begin
      starve_cnt <= 2'd0;
    end else if (slot_ok) begin
      if (!i_CMD_REQ) begin
        starve_cnt <= 2'd0;
      end else if (grant) begin
        if (cmd_win)                starve_cnt <= 2'd0;
        else if (starve_cnt != 2'd3) starve_cnt <= starve_cnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_ika9958_vram_arb.sv
// Directed bench for ika9958_vram_arb: one task per scenario, each with its
// own hand-computed expectations.
module tb_ika9958_vram_arb;

  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          i_RST_n, i_CEN, i_SLOT_START, i_SLOT_FREE, i_DISP_OFF;
  logic          i_CPU_REQ, i_CPU_RD, i_CMD_REQ, i_CMD_RD;
  logic [AW-1:0] i_CPU_ADDR, i_CMD_ADDR;
  logic [7:0]    i_CPU_WDATA, i_CMD_WDATA, i_VDI;
  logic          o_CPU_ACK, o_CMD_ACK, o_VDO_OE, o_RAS_n, o_CAS_n, o_WE_n, o_BUSY;
  logic [7:0]    o_RDATA, o_VDO;
  logic [AW-1:0] o_VA;
  logic [1:0]    o_DBG_STATE, o_DBG_STARVE;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cpu_acks = 0;
  int cmd_acks = 0;
  int wide_acks = 0;
  logic prev_cpu = 1'b0;
  logic prev_cmd = 1'b0;

  // snapshot taken right after each CEN edge
  logic          s_ras, s_cas, s_we, s_oe, s_busy, s_cpu_ack, s_cmd_ack;
  logic [7:0]    s_vdo;
  logic [AW-1:0] s_va;
  logic [1:0]    s_state, s_starve;

  ika9958_vram_arb #(.AW(AW), .STARVE_MAX(2)) dut (
    .i_XTAL1(clk), .i_RST_n(i_RST_n), .i_CEN(i_CEN),
    .i_SLOT_START(i_SLOT_START), .i_SLOT_FREE(i_SLOT_FREE), .i_DISP_OFF(i_DISP_OFF),
    .i_CPU_REQ(i_CPU_REQ), .i_CPU_RD(i_CPU_RD), .i_CPU_ADDR(i_CPU_ADDR),
    .i_CPU_WDATA(i_CPU_WDATA), .o_CPU_ACK(o_CPU_ACK),
    .i_CMD_REQ(i_CMD_REQ), .i_CMD_RD(i_CMD_RD), .i_CMD_ADDR(i_CMD_ADDR),
    .i_CMD_WDATA(i_CMD_WDATA), .o_CMD_ACK(o_CMD_ACK),
    .o_RDATA(o_RDATA), .o_VA(o_VA), .o_VDO(o_VDO), .o_VDO_OE(o_VDO_OE), .i_VDI(i_VDI),
    .o_RAS_n(o_RAS_n), .o_CAS_n(o_CAS_n), .o_WE_n(o_WE_n), .o_BUSY(o_BUSY),
    .o_DBG_STATE(o_DBG_STATE), .o_DBG_STARVE(o_DBG_STARVE)
  );

  // clock / reset
  always #5 clk = ~clk;

  // ack monitor: counts pulses and flags any pulse wider than one clock
  always @(negedge clk) begin
    if (o_CPU_ACK) cpu_acks++;
    if (o_CMD_ACK) cmd_acks++;
    if ((o_CPU_ACK && prev_cpu) || (o_CMD_ACK && prev_cmd)) wide_acks++;
    prev_cpu = o_CPU_ACK;
    prev_cmd = o_CMD_ACK;
  end

  // one CEN period: CEN edge (optionally a slot start), then one idle clock
  task automatic step(input logic slot);
    @(negedge clk);
    i_CEN = 1'b1;
    i_SLOT_START = slot;
    @(negedge clk);
    s_ras = o_RAS_n;  s_cas = o_CAS_n;  s_we = o_WE_n;  s_oe = o_VDO_OE;
    s_busy = o_BUSY;  s_cpu_ack = o_CPU_ACK;  s_cmd_ack = o_CMD_ACK;
    s_vdo = o_VDO;  s_va = o_VA;  s_state = o_DBG_STATE;  s_starve = o_DBG_STARVE;
    i_CEN = 1'b0;
    i_SLOT_START = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    total_cnt++;
    if ({o_RAS_n, o_CAS_n, o_WE_n, o_VDO_OE, o_BUSY, o_CPU_ACK, o_CMD_ACK} !== 7'b1110000)
      $display("FAIL reset_ctrl: got %b want 1110000",
               {o_RAS_n, o_CAS_n, o_WE_n, o_VDO_OE, o_BUSY, o_CPU_ACK, o_CMD_ACK});
    else pass_cnt++;
    total_cnt++;
    if ({o_VA, o_VDO, o_RDATA} !== '0)
      $display("FAIL reset_data: va %h vdo %h rdata %h want 0", o_VA, o_VDO, o_RDATA);
    else pass_cnt++;
    total_cnt++;
    if ({o_DBG_STATE, o_DBG_STARVE} !== 4'b0000)
      $display("FAIL reset_state: state %0d starve %0d want 0 0", o_DBG_STATE, o_DBG_STARVE);
    else pass_cnt++;
  endtask

  task automatic test_cpu_write();
    int c0, d0;
    c0 = cpu_acks; d0 = cmd_acks;
    i_CPU_REQ = 1'b1; i_CPU_RD = 1'b0; i_CPU_ADDR = 17'h12345; i_CPU_WDATA = 8'hA5;
    step(1'b1);
    total_cnt++;
    if ({s_ras, s_cas, s_we, s_busy} !== 4'b0111 || s_va !== 17'h12345)
      $display("FAIL wr_addr: ras/cas/we/busy %b va %h want 0111 12345",
               {s_ras, s_cas, s_we, s_busy}, s_va);
    else pass_cnt++;
    step(1'b0);
    total_cnt++;
    if ({s_ras, s_cas, s_we, s_oe} !== 4'b0001 || s_vdo !== 8'hA5)
      $display("FAIL wr_data: ras/cas/we/oe %b vdo %h want 0001 a5", {s_ras, s_cas, s_we, s_oe}, s_vdo);
    else pass_cnt++;
    step(1'b0);
    i_CPU_REQ = 1'b0;
    total_cnt++;
    if ({s_cpu_ack, s_cmd_ack, s_ras, s_cas, s_we, s_oe} !== 6'b101110 || s_va !== 17'h12345)
      $display("FAIL wr_done: acks/strobes %b va %h want 101110 12345",
               {s_cpu_ack, s_cmd_ack, s_ras, s_cas, s_we, s_oe}, s_va);
    else pass_cnt++;
    step(1'b0);
    total_cnt++;
    if ({s_state, s_busy} !== 3'b000 || cpu_acks - c0 != 1 || cmd_acks != d0)
      $display("FAIL wr_end: state %0d busy %b cpu_acks %0d cmd_acks %0d want 0 0 1 0",
               s_state, s_busy, cpu_acks - c0, cmd_acks - d0);
    else pass_cnt++;
  endtask

  task automatic test_cmd_read();
    int c0, d0;
    logic we_seen;
    c0 = cpu_acks; d0 = cmd_acks; we_seen = 1'b1;
    i_CMD_REQ = 1'b1; i_CMD_RD = 1'b1; i_CMD_ADDR = 17'h00010; i_VDI = 8'h3C;
    step(1'b1);
    we_seen &= s_we;
    total_cnt++;
    if (s_va !== 17'h00010 || s_ras !== 1'b0)
      $display("FAIL rd_addr: va %h ras %b want 00010 0", s_va, s_ras);
    else pass_cnt++;
    step(1'b0);
    we_seen &= s_we;
    total_cnt++;
    if ({s_cas, s_oe} !== 2'b00)
      $display("FAIL rd_data: cas/oe %b want 00", {s_cas, s_oe});
    else pass_cnt++;
    step(1'b0);
    we_seen &= s_we;
    i_CMD_REQ = 1'b0;
    step(1'b0);
    total_cnt++;
    if (o_RDATA !== 8'h3C)
      $display("FAIL rd_rdata: got %h want 3c", o_RDATA);
    else pass_cnt++;
    total_cnt++;
    if (cmd_acks - d0 != 1 || cpu_acks != c0 || we_seen !== 1'b1)
      $display("FAIL rd_ack: cmd_acks %0d cpu_acks %0d we_high %b want 1 0 1",
               cmd_acks - d0, cpu_acks - c0, we_seen);
    else pass_cnt++;
  endtask

  task automatic test_starvation();
    logic [1:0] exp_starve [6] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
    logic [5:0] cmd_tbl = 6'b100100;   // bit i set: slot i goes to CMD
    logic [1:0] got, exp;
    int c0, d0;
    i_CPU_REQ = 1'b1; i_CPU_RD = 1'b1; i_CMD_REQ = 1'b1; i_CMD_RD = 1'b0;
    for (int i = 0; i < 6; i++) begin
      c0 = cpu_acks; d0 = cmd_acks;
      step(1'b1);
      total_cnt++;
      if (s_starve !== exp_starve[i])
        $display("FAIL starve_cnt_%0d: got %0d want %0d", i, s_starve, exp_starve[i]);
      else pass_cnt++;
      step(1'b0); step(1'b0); step(1'b0);
      got = {(cmd_acks - d0) == 1, (cpu_acks - c0) == 1};
      exp = cmd_tbl[i] ? 2'b10 : 2'b01;
      total_cnt++;
      if (got !== exp)
        $display("FAIL starve_owner_%0d: cmd/cpu %b want %b", i, got, exp);
      else pass_cnt++;
    end
    i_CPU_REQ = 1'b0; i_CMD_REQ = 1'b0;
  endtask

  task automatic test_non_free();
    int c0;
    logic quiet;
    quiet = 1'b1;
    i_SLOT_FREE = 1'b0; i_DISP_OFF = 1'b0;
    i_CPU_REQ = 1'b1; i_CPU_RD = 1'b1; i_CPU_ADDR = 17'h1FFFF; i_VDI = 8'h5A;
    c0 = cpu_acks;
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      quiet &= s_ras & s_cas & s_we & ~s_busy;
    end
    total_cnt++;
    if (quiet !== 1'b1 || cpu_acks != c0)
      $display("FAIL nonfree_quiet: quiet %b acks %0d want 1 0", quiet, cpu_acks - c0);
    else pass_cnt++;
    i_DISP_OFF = 1'b1;
    step(1'b1);
    total_cnt++;
    if ({s_ras, s_busy} !== 2'b01 || s_va !== 17'h1FFFF)
      $display("FAIL dispoff_grant: ras/busy %b va %h want 01 1ffff", {s_ras, s_busy}, s_va);
    else pass_cnt++;
    step(1'b0); step(1'b0);
    i_CPU_REQ = 1'b0;
    step(1'b0);
    total_cnt++;
    if (cpu_acks - c0 != 1 || o_RDATA !== 8'h5A)
      $display("FAIL dispoff_done: acks %0d rdata %h want 1 5a", cpu_acks - c0, o_RDATA);
    else pass_cnt++;
    i_DISP_OFF = 1'b0; i_SLOT_FREE = 1'b1;
  endtask

  task automatic test_overlap();
    logic [7:0] exp_busy = 8'b0111_0111;   // bit i: busy after step i
    logic [7:0] got_busy;
    int c0;
    c0 = cpu_acks;
    got_busy = 8'd0;
    i_CPU_REQ = 1'b1; i_CPU_RD = 1'b0; i_CPU_WDATA = 8'h0F;
    for (int i = 0; i < 8; i++) begin
      step((i % 2) == 0);
      got_busy[i] = s_busy;
      if (i == 5) i_CPU_REQ = 1'b0;   // drop during DATA of the second access
    end
    total_cnt++;
    if (got_busy !== exp_busy)
      $display("FAIL overlap_busy: got %b want %b", got_busy, exp_busy);
    else pass_cnt++;
    total_cnt++;
    if (cpu_acks - c0 != 2)
      $display("FAIL overlap_acks: got %0d want 2", cpu_acks - c0);
    else pass_cnt++;
    step(1'b1);
    total_cnt++;
    if (s_busy !== 1'b0)
      $display("FAIL no_req_slot: busy %b want 0", s_busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int c0, d0;
    i_CPU_REQ = 1'b1; i_CPU_RD = 1'b0; i_CMD_REQ = 1'b1; i_CMD_RD = 1'b1;
    step(1'b1);
    total_cnt++;
    if (s_starve !== 2'd1 || s_ras !== 1'b0)
      $display("FAIL rstmid_pre: starve %0d ras %b want 1 0", s_starve, s_ras);
    else pass_cnt++;
    step(1'b0);
    total_cnt++;
    if ({s_state, s_cas, s_we} !== 4'b1000)
      $display("FAIL rstmid_data: state/cas/we %b want 1000", {s_state, s_cas, s_we});
    else pass_cnt++;
    c0 = cpu_acks; d0 = cmd_acks;
    i_RST_n = 1'b0;
    #1;
    total_cnt++;
    if ({o_RAS_n, o_CAS_n, o_WE_n, o_VDO_OE, o_BUSY, o_DBG_STATE, o_DBG_STARVE} !== 9'b111000000)
      $display("FAIL rstmid_async: got %b want 111000000",
               {o_RAS_n, o_CAS_n, o_WE_n, o_VDO_OE, o_BUSY, o_DBG_STATE, o_DBG_STARVE});
    else pass_cnt++;
    repeat (3) @(negedge clk);
    i_RST_n = 1'b1;
    i_CPU_REQ = 1'b0;
    #1;
    total_cnt++;
    if (cpu_acks != c0 || cmd_acks != d0)
      $display("FAIL rstmid_noack: cpu %0d cmd %0d want 0 0", cpu_acks - c0, cmd_acks - d0);
    else pass_cnt++;
    i_VDI = 8'h77;
    step(1'b1);
    total_cnt++;
    if ({s_busy, s_ras} !== 2'b10 || s_va !== 17'h00010)
      $display("FAIL rstmid_regrant: busy/ras %b va %h want 10 00010", {s_busy, s_ras}, s_va);
    else pass_cnt++;
    step(1'b0); step(1'b0);
    i_CMD_REQ = 1'b0;
    step(1'b0);
    total_cnt++;
    if (cmd_acks - d0 != 1 || cpu_acks != c0 || o_RDATA !== 8'h77)
      $display("FAIL rstmid_after: cmd %0d cpu %0d rdata %h want 1 0 77",
               cmd_acks - d0, cpu_acks - c0, o_RDATA);
    else pass_cnt++;
  endtask

  initial begin
    i_RST_n = 1'b0; i_CEN = 1'b0; i_SLOT_START = 1'b0; i_SLOT_FREE = 1'b1; i_DISP_OFF = 1'b0;
    i_CPU_REQ = 1'b0; i_CPU_RD = 1'b0; i_CPU_ADDR = '0; i_CPU_WDATA = 8'd0;
    i_CMD_REQ = 1'b0; i_CMD_RD = 1'b0; i_CMD_ADDR = '0; i_CMD_WDATA = 8'd0;
    i_VDI = 8'd0;
    repeat (2) @(negedge clk);
    #1;
    test_reset();
    @(negedge clk);
    i_RST_n = 1'b1;
    #1;
    test_reset();
    test_cpu_write();
    test_cmd_read();
    test_starvation();
    test_non_free();
    test_overlap();
    test_reset_mid();
    total_cnt++;
    if (wide_acks != 0)
      $display("FAIL ack_width: %0d acks wider than one clock want 0", wide_acks);
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ika9958_vram_arb.md
# ika9958_vram_arb

VRAM access arbiter and sequencer for the IKA9958 core. It shares the free VRAM access slots left over by display and refresh fetches between the CPU port and the command engine. For each granted slot it runs a fixed RAS/CAS/WE sequence and returns read data with a one-cycle acknowledge. It sits between the screen-timing slot generator and the external DRAM pins, clocked from the master crystal clock and advanced by the dot-clock enable.

## Interface
Parameters:
- AW, 17, VRAM address width (128 KiB).
- STARVE_MAX, 2, consecutive CPU wins allowed while the command engine waits.

Ports (name, direction, width, meaning):
- i_XTAL1, in, 1, master clock; all flops on its rising edge.
- i_RST_n, in, 1, reset; **asynchronous, active-low**.
- i_CEN, in, 1, dot-clock enable; state advances only on edges where i_CEN=1.
- i_SLOT_START, in, 1, first dot of an access slot; qualified by i_CEN.
- i_SLOT_FREE, in, 1, slot not claimed by display/refresh/sprite; sampled with i_SLOT_START.
- i_DISP_OFF, in, 1, blanking/display disabled; every slot start is treated as free.
- i_CPU_REQ, i_CPU_RD, in, 1 each, CPU request level and read(1)/write(0).
- i_CPU_ADDR, in, AW, CPU address.
- i_CPU_WDATA, in, 8, CPU write data.
- o_CPU_ACK, out, 1, one-clock completion pulse.
- i_CMD_REQ, i_CMD_RD, i_CMD_ADDR, i_CMD_WDATA: same as the CPU set, for the command engine.
- o_CMD_ACK, out, 1, one-clock completion pulse.
- o_RDATA, out, 8, read data, valid from the ack cycle until the next ack.
- o_VA, out, AW, DRAM address.
- o_VDO, out, 8, DRAM write data.
- o_VDO_OE, out, 1, data bus output enable.
- i_VDI, in, 8, DRAM read data.
- o_RAS_n, o_CAS_n, o_WE_n, out, 1 each, DRAM strobes.
- o_BUSY, out, 1, high whenever state≠IDLE.

## Operation
- States: IDLE, ADDR, DATA, DONE.
- Grant test: in IDLE, at a CEN edge with i_SLOT_START & (i_SLOT_FREE | i_DISP_OFF) and at least one REQ high.
  - Winner is CPU unless CMD_REQ is high and starve_cnt ≥ STARVE_MAX; then CMD wins.
  - The winner's RD/ADDR/WDATA and an owner bit are latched.
- starve_cnt (2 bits, saturating):
  - +1 when CPU wins while CMD_REQ is high.
  - Cleared when CMD wins, or at a free slot start where CMD_REQ is low.
- ADDR: o_VA = latched address; o_RAS_n=0.
- DATA: o_CAS_n=0. For writes, o_WE_n=0, o_VDO_OE=1, o_VDO = latched data.
- DONE:
  - All strobes deasserted; o_VDO_OE=0.
  - For reads, o_RDATA ← i_VDI sampled on the DATA→DONE edge.
  - The owner's ACK pulses for exactly one i_XTAL1 cycle (the first clock of DONE).
- Next CEN edge: DONE→IDLE. A new grant is possible only from IDLE.
- REQ handshake:
  - A requester holds REQ and its fields stable until its ACK.
  - Deasserting REQ after grant does not abort the access; the ACK is still issued.
  - A requester sampling its ACK must drop REQ or present a new request on the next cycle. A REQ still high in IDLE is a new request.
- A slot start in any state other than IDLE is ignored (no queueing). A slot start with neither REQ high does nothing.
- Reset value of every output:
  - Strobes high: o_RAS_n=o_CAS_n=o_WE_n=1.
  - Zero: o_VA=0, o_VDO=0, o_VDO_OE=0, o_RDATA=0, both ACKs 0, o_BUSY=0.
  - Internal: state=IDLE, starve_cnt=0.
- Reset asserted mid-access: outputs return to reset values immediately (async) and the pending access is lost with no ACK. After release, the first eligible slot start re-grants.

## Timing
- Let k be the CEN edge sampling a granted slot start.
  - After k: ADDR, o_RAS_n=0, o_BUSY=1.
  - After k+1: DATA, o_CAS_n=0.
  - After k+2: DONE; ACK high for one clock; o_RDATA valid.
  - After k+3: IDLE.
- Access latency is 3 CEN periods from slot start to ACK, and 4 CEN periods of occupancy.
- Edges with i_CEN=0 hold all state. ACK is still only one clock wide, not one CEN period wide.
- o_VA is stable from ADDR through DONE. o_WE_n falls together with o_CAS_n, not before.
- Slot starts closer together than 4 CEN periods are legal; those landing in a non-IDLE state are dropped.

## Test plan
- CPU write alone: CPU_REQ=1, RD=0, ADDR=0x1_2345, WDATA=0xA5, free slot.
  - Required: o_VA=0x12345; RAS_n low at k+1, CAS_n and WE_n low at k+2; o_VDO=0xA5 with OE; CPU_ACK one clock after k+2; CMD_ACK never.
- CMD read alone: i_VDI=0x3C, ADDR=0x0_0010.
  - Required: CMD_ACK pulses once; o_RDATA=0x3C; WE_n stays high throughout.
- Starvation: both REQ held high over 6 free slots.
  - Required grant order CPU, CPU, CMD, CPU, CPU, CMD; starve_cnt returns to 0 after each CMD grant.
- Non-free slot: i_SLOT_FREE=0, i_DISP_OFF=0, CPU_REQ=1.
  - Required: no strobe activity, no ACK.
  - Then set i_DISP_OFF=1: the next slot start is granted.
- Overlap and early drop: slot starts every 2 CEN periods with CPU_REQ=1.
  - Required: every other slot start is ignored while BUSY.
  - Dropping CPU_REQ during DATA still yields one ACK.
- Reset mid-access: assert i_RST_n=0 in DATA.
  - Required: strobes high in the same cycle, no ACK, state IDLE, starve_cnt=0.
  - After release, a pending CMD_REQ is granted at the first free slot.
